fp16_add_sub: RTL and testbench

- Pipelined IEEE-754 binary16 (half-precision) adder/subtractor for the FP16 DSP-slice datapath.
- Computes a+b or a−b with round-to-nearest-even.
- Accepts a new operand pair every clock; result and 5-bit status flags emerge a fixed number of cycles later.

---
 rtl/fp16_pkg.sv | 51 +++++
 rtl/fp16_lzc.sv | 22 ++
 rtl/fp16_add_sub.sv | 223 ++++++++++++++++++++++
 tb/tb_fp16_add_sub.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_pkg
//  Brief    : Shared widths, constants, flag indices and operand unpacking
//             for the binary16 add/subtract datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package fp16_pkg;

   localparam int EXP_W = 5;
   localparam int MAN_W = 10;
   localparam int BIAS  = 15;
   localparam int SIG_W = MAN_W + 1;   // significand including hidden bit
   localparam int EXT_W = SIG_W + 3;   // significand plus guard, round, sticky

   localparam logic [15:0] QNAN    = 16'h7E00;
   localparam logic [15:0] POS_INF = 16'h7C00;

   localparam int FLAG_INVALID   = 4;
   localparam int FLAG_OVERFLOW  = 3;
   localparam int FLAG_UNDERFLOW = 2;
   localparam int FLAG_ZERO      = 1;
   localparam int FLAG_INEXACT   = 0;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SIG_W-1:0] sig;
      logic             is_zero;
      logic             is_inf;
      logic             is_nan;
   } fp16_unpacked_t;

   // Split a binary16 word; subnormals flush to a signed zero significand.
   function automatic fp16_unpacked_t fp16_unpack(input logic [15:0] x, input logic negate);
      fp16_unpacked_t   u;
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
      e         = x[14:10];
      m         = x[9:0];
      u.sign    = x[15] ^ negate;
      u.exp     = e;
      u.sig     = (e != '0) ? {1'b1, m} : '0;
      u.is_zero = (e == '0);
      u.is_inf  = (e == '1) && (m == '0);
      u.is_nan  = (e == '1) && (m != '0);
      return u;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_lzc.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_lzc
//  Brief    : 12-bit combinational leading-zero counter; all-zero input
//             returns 12.
//  Revision : 1.0 - initial release
// ============================================================================
module fp16_lzc (
   input  logic [11:0] i_bits,
   output logic [3:0]  o_count
);

   // scan upward so the highest set bit makes the final assignment
   always_comb begin
      o_count = 4'd12;
      for (int i = 0; i < 12; i++) begin
         if (i_bits[i]) o_count = 4'(11 - i);
      end
   end

endmodule
`default_nettype wire

// File: rtl/fp16_add_sub.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_add_sub
//  Brief    : Four-stage pipelined binary16 adder/subtractor, round to
//             nearest even, flush-to-zero for subnormal inputs and outputs.
//             Operands captured on an edge appear on result/flags after the
//             fourth edge counting the capture edge.
//  Revision : 1.0 - initial release
// ============================================================================
module fp16_add_sub #(
   parameter int DWIDTH = 16,
   parameter int EXP_W  = fp16_pkg::EXP_W,
   parameter int MAN_W  = fp16_pkg::MAN_W,
   parameter int BIAS   = fp16_pkg::BIAS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] a,
   input  logic [DWIDTH-1:0] b,
   input  logic              operation,
   output logic [DWIDTH-1:0] result,
   output logic [4:0]        flags
);
   import fp16_pkg::*;

   localparam int c_exp_max = 2 * BIAS + 1;
   localparam int c_shift_w = SIG_W + 16;

   // stage 1: unpacked operands
   fp16_unpacked_t s1_a_d, s1_a_q, s1_b_d, s1_b_q;
   logic           s1_live_d, s1_live_q;

   // stage 2: swapped and aligned operands plus special-case result
   logic             s2_sign_d, s2_sign_q, s2_sub_d, s2_sub_q;
   logic             s2_zero_sign_d, s2_zero_sign_q, s2_live_d, s2_live_q;
   logic [EXP_W-1:0] s2_exp_d, s2_exp_q;
   logic [EXT_W-1:0] s2_big_d, s2_big_q, s2_small_d, s2_small_q;
   logic             s2_special_d, s2_special_q;
   logic [15:0]      s2_special_res_d, s2_special_res_q;
   logic [4:0]       s2_special_flags_d, s2_special_flags_q;

   // stage 3: normalized sum
   logic              s3_sign_d, s3_sign_q, s3_zero_sign_d, s3_zero_sign_q;
   logic              s3_live_d, s3_live_q, s3_special_d, s3_special_q;
   logic signed [6:0] s3_exp_d, s3_exp_q;
   logic [EXT_W-1:0]  s3_norm_d, s3_norm_q;
   logic [15:0]       s3_special_res_d, s3_special_res_q;
   logic [4:0]        s3_special_flags_d, s3_special_flags_q;

   // stage 4: packed output
   logic [DWIDTH-1:0] s4_res_d, s4_res_q;
   logic [4:0]        s4_flags_d, s4_flags_q;

   logic                 w_swap, w_big_sign;
   logic [EXP_W-1:0]     w_big_exp, w_small_exp, w_diff;
   logic [SIG_W-1:0]     w_big_sig, w_small_sig;
   logic [c_shift_w-1:0] w_shift;
   logic [EXT_W:0]       w_sum;
   logic [3:0]           w_lzc;
   logic                 w_round_up, w_inexact;
   logic [MAN_W:0]       w_frac_rnd;
   logic signed [6:0]    w_exp_rnd;

   // stage 1: unpack, folding subtraction into b's sign
   always_comb begin
      s1_a_d    = fp16_unpack(a, 1'b0);
      s1_b_d    = fp16_unpack(b, operation);
      s1_live_d = 1'b1;
   end

   // stage 2: order by magnitude, align the smaller, resolve NaN/Inf cases
   always_comb begin
      w_swap      = !s1_b_q.is_zero &&
                    (s1_a_q.is_zero || ({s1_b_q.exp, s1_b_q.sig} > {s1_a_q.exp, s1_a_q.sig}));
      w_big_sign  = w_swap ? s1_b_q.sign : s1_a_q.sign;
      w_big_exp   = w_swap ? s1_b_q.exp  : s1_a_q.exp;
      w_big_sig   = w_swap ? s1_b_q.sig  : s1_a_q.sig;
      w_small_exp = w_swap ? s1_a_q.exp  : s1_b_q.exp;
      w_small_sig = w_swap ? s1_a_q.sig  : s1_b_q.sig;
      w_diff      = w_big_exp - w_small_exp;
      // bits that fall below the sticky position are OR-reduced into it
      w_shift     = {w_small_sig, 16'd0} >> w_diff;

      s2_sign_d      = w_big_sign;
      s2_sub_d       = s1_a_q.sign ^ s1_b_q.sign;
      s2_zero_sign_d = s1_a_q.sign & s1_b_q.sign;
      s2_exp_d       = w_big_exp;
      s2_big_d       = {w_big_sig, 3'b000};
      s2_small_d     = (w_diff > 5'd13) ? {13'd0, |w_small_sig}
                                        : {w_shift[c_shift_w-1:14], |w_shift[13:0]};
      s2_live_d      = s1_live_q;

      s2_special_d       = 1'b0;
      s2_special_res_d   = '0;
      s2_special_flags_d = '0;
      if (s1_a_q.is_nan || s1_b_q.is_nan ||
          (s1_a_q.is_inf && s1_b_q.is_inf && (s1_a_q.sign != s1_b_q.sign))) begin
         s2_special_d                     = 1'b1;
         s2_special_res_d                 = QNAN;
         s2_special_flags_d[FLAG_INVALID] = 1'b1;
      end else if (s1_a_q.is_inf) begin
         s2_special_d     = 1'b1;
         s2_special_res_d = {s1_a_q.sign, POS_INF[14:0]};
      end else if (s1_b_q.is_inf) begin
         s2_special_d     = 1'b1;
         s2_special_res_d = {s1_b_q.sign, POS_INF[14:0]};
      end
   end

   fp16_lzc u_lzc (
      .i_bits  (w_sum[13:2]),
      .o_count (w_lzc)
   );

   // stage 3: magnitude add/subtract, then normalize the leading one to bit 13
   always_comb begin
      w_sum = s2_sub_q ? ({1'b0, s2_big_q} - {1'b0, s2_small_q})
                       : ({1'b0, s2_big_q} + {1'b0, s2_small_q});
      if (w_sum[EXT_W]) begin
         s3_norm_d = {w_sum[EXT_W:2], w_sum[1] | w_sum[0]};
         s3_exp_d  = $signed({2'b00, s2_exp_q}) + 7'sd1;
      end else begin
         s3_norm_d = w_sum[EXT_W-1:0] << w_lzc;
         s3_exp_d  = $signed({2'b00, s2_exp_q}) - $signed({3'b000, w_lzc});
      end
      s3_sign_d          = s2_sign_q;
      s3_zero_sign_d     = s2_zero_sign_q;
      s3_live_d          = s2_live_q;
      s3_special_d       = s2_special_q;
      s3_special_res_d   = s2_special_res_q;
      s3_special_flags_d = s2_special_flags_q;
   end

   // stage 4: round to nearest even and pack, a zero bit 13 means an exact zero sum
   always_comb begin
      w_inexact  = |s3_norm_q[2:0];
      w_round_up = s3_norm_q[2] & (s3_norm_q[1] | s3_norm_q[0] | s3_norm_q[3]);
      w_frac_rnd = {1'b0, s3_norm_q[12:3]} + {{MAN_W{1'b0}}, w_round_up};
      w_exp_rnd  = s3_exp_q + $signed({6'd0, w_frac_rnd[MAN_W]});

      s4_res_d   = '0;
      s4_flags_d = '0;
      if (!s3_live_q) begin
         s4_res_d   = '0;
      end else if (s3_special_q) begin
         s4_res_d   = s3_special_res_q;
         s4_flags_d = s3_special_flags_q;
      end else if (!s3_norm_q[EXT_W-1]) begin
         s4_res_d              = {s3_zero_sign_q, 15'd0};
         s4_flags_d[FLAG_ZERO] = 1'b1;
      end else if (w_exp_rnd >= $signed(7'(c_exp_max))) begin
         s4_res_d                  = {s3_sign_q, POS_INF[14:0]};
         s4_flags_d[FLAG_OVERFLOW] = 1'b1;
         s4_flags_d[FLAG_INEXACT]  = 1'b1;
      end else if (w_exp_rnd <= 7'sd0) begin
         s4_res_d                   = {s3_sign_q, 15'd0};
         s4_flags_d[FLAG_UNDERFLOW] = 1'b1;
         s4_flags_d[FLAG_ZERO]      = 1'b1;
         s4_flags_d[FLAG_INEXACT]   = 1'b1;
      end else begin
         s4_res_d                 = {s3_sign_q, w_exp_rnd[EXP_W-1:0], w_frac_rnd[MAN_W-1:0]};
         s4_flags_d[FLAG_INEXACT] = w_inexact;
      end
   end

   // pipeline registers, all cleared asynchronously so reset drains zeros
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_a_q             <= '0;
         s1_b_q             <= '0;
         s1_live_q          <= 1'b0;
         s2_sign_q          <= 1'b0;
         s2_sub_q           <= 1'b0;
         s2_zero_sign_q     <= 1'b0;
         s2_live_q          <= 1'b0;
         s2_exp_q           <= '0;
         s2_big_q           <= '0;
         s2_small_q         <= '0;
         s2_special_q       <= 1'b0;
         s2_special_res_q   <= '0;
         s2_special_flags_q <= '0;
         s3_sign_q          <= 1'b0;
         s3_zero_sign_q     <= 1'b0;
         s3_live_q          <= 1'b0;
         s3_special_q       <= 1'b0;
         s3_exp_q           <= '0;
         s3_norm_q          <= '0;
         s3_special_res_q   <= '0;
         s3_special_flags_q <= '0;
         s4_res_q           <= '0;
         s4_flags_q         <= '0;
      end else begin
         s1_a_q             <= s1_a_d;
         s1_b_q             <= s1_b_d;
         s1_live_q          <= s1_live_d;
         s2_sign_q          <= s2_sign_d;
         s2_sub_q           <= s2_sub_d;
         s2_zero_sign_q     <= s2_zero_sign_d;
         s2_live_q          <= s2_live_d;
         s2_exp_q           <= s2_exp_d;
         s2_big_q           <= s2_big_d;
         s2_small_q         <= s2_small_d;
         s2_special_q       <= s2_special_d;
         s2_special_res_q   <= s2_special_res_d;
         s2_special_flags_q <= s2_special_flags_d;
         s3_sign_q          <= s3_sign_d;
         s3_zero_sign_q     <= s3_zero_sign_d;
         s3_live_q          <= s3_live_d;
         s3_special_q       <= s3_special_d;
         s3_exp_q           <= s3_exp_d;
         s3_norm_q          <= s3_norm_d;
         s3_special_res_q   <= s3_special_res_d;
         s3_special_flags_q <= s3_special_flags_d;
         s4_res_q           <= s4_res_d;
         s4_flags_q         <= s4_flags_d;
      end
   end

   assign result = s4_res_q;
   assign flags  = s4_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp16_add_sub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp16_add_sub
//  Brief    : Self-checking bench for fp16_add_sub: directed vectors with
//             hand-derived results, then random vectors against an exact
//             integer-arithmetic reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp16_add_sub;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a, b;
   logic        operation;
   logic [15:0] result;
   logic [4:0]  flags;

   typedef struct {
      logic [15:0] res;
      logic [4:0]  flg;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   fp16_add_sub dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .operation (operation),
      .result    (result),
      .flags     (flags)
   );

   // Exact value of each operand as an integer count of 2^-24, summed and
   // rounded to 11 significant bits with ties to even.
   function automatic logic [20:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                             input logic op);
      logic   sx, sy, sg, inx;
      int     ex, ey, p, e, sh;
      longint mx, my, s, mag, keep, rem, half;
      sx = x[15];
      sy = y[15] ^ op;
      ex = int'(x[14:10]);
      ey = int'(y[14:10]);
      if ((ex == 31 && x[9:0] != 0) || (ey == 31 && y[9:0] != 0))
         return {16'h7E00, 5'b10000};
      if (ex == 31 && ey == 31)
         return (sx != sy) ? {16'h7E00, 5'b10000} : {sx, 15'h7C00, 5'b00000};
      if (ex == 31) return {sx, 15'h7C00, 5'b00000};
      if (ey == 31) return {sy, 15'h7C00, 5'b00000};
      mx = (ex == 0) ? 0 : ((longint'(x[9:0]) + 1024) << (ex - 1));
      my = (ey == 0) ? 0 : ((longint'(y[9:0]) + 1024) << (ey - 1));
      s  = (sx ? -mx : mx) + (sy ? -my : my);
      if (s == 0) return {sx & sy, 15'd0, 5'b00010};
      sg  = (s < 0);
      mag = sg ? -s : s;
      p   = 0;
      for (int i = 0; i < 48; i++) if (mag[i]) p = i;
      inx = 1'b0;
      if (p > 10) begin
         sh   = p - 10;
         keep = mag >> sh;
         rem  = mag - (keep << sh);
         half = longint'(1) << (sh - 1);
         inx  = (rem != 0);
         if (rem > half || (rem == half && keep[0])) keep = keep + 1;
         if (keep == 2048) begin
            keep = 1024;
            p    = p + 1;
         end
      end else begin
         keep = mag << (10 - p);
      end
      e = p - 9;
      if (e >= 31) return {sg, 15'h7C00, 5'b01001};
      if (e <= 0)  return {sg, 15'd0, 5'b00111};
      return {sg, 5'(e), keep[9:0], 4'b0000, inx};
   endfunction

   // compare the output against the vector captured three edges earlier
   task automatic check_out();
      exp_t e;
      if (exp_q.size() == 4) begin
         e = exp_q.pop_front();
         n_tests++;
         assert (result === e.res && flags === e.flg)
         else begin
            n_fail++;
            $error("FAIL %s: result=%h flags=%b, expected result=%h flags=%b",
                   e.tag, result, flags, e.res, e.flg);
         end
      end
   endtask

   task automatic apply(input logic [15:0] x, input logic [15:0] y, input logic op,
                        input logic [15:0] er, input logic [4:0] ef, input string tag);
      exp_t e;
      a         = x;
      b         = y;
      operation = op;
      e.res     = er;
      e.flg     = ef;
      e.tag     = tag;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic step(input logic [15:0] x, input logic [15:0] y, input logic op,
                       input logic [15:0] er, input logic [4:0] ef, input string tag);
      @(negedge clk);
      apply(x, y, op, er, ef, tag);
   endtask

   task automatic rstep(input logic [15:0] x, input logic [15:0] y, input logic op,
                        input string tag);
      logic [20:0] r;
      r = ref_model(x, y, op);
      step(x, y, op, r[20:5], r[4:0], tag);
   endtask

   initial begin
      exp_t        z;
      logic [15:0] x, y;
      rst       = 1'b1;
      a         = 16'h3C00;
      b         = 16'h3C00;
      operation = 1'b0;
      #1 rst    = 1'b0;

      // reset held with live operands: outputs stay zero
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++;
         assert (result === 16'h0000 && flags === 5'b00000)
         else begin
            n_fail++;
            $error("FAIL reset_hold: result=%h flags=%b, expected result=0000 flags=00000",
                   result, flags);
         end
      end

      // release: three drained zero outputs, then the first sum
      @(negedge clk);
      rst   = 1'b1;
      z.res = 16'h0000;
      z.flg = 5'b00000;
      z.tag = "drain";
      for (int i = 0; i < 3; i++) exp_q.push_back(z);
      apply(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 5'b00000, "rst_first");

      step(16'h1234, 16'h4321, 1'b0, 16'h4321, 5'b00001, "add_1234_4321");
      step(16'hE37B, 16'h1AB4, 1'b0, 16'hE37B, 5'b00001, "add_E37B_1AB4");
      step(16'hABCD, 16'h9876, 1'b0, 16'hAC0A, 5'b00001, "add_ABCD_9876");
      step(16'hABCD, 16'h9876, 1'b1, 16'hAB86, 5'b00001, "sub_ABCD_9876");
      step(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 5'b00010, "sub_equal");
      step(16'h4000, 16'h3C00, 1'b1, 16'h3C00, 5'b00000, "sub_4000_3C00");
      step(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 5'b00000, "add_one_one");
      step(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 5'b00001, "tie_even");
      step(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 5'b01001, "overflow");
      step(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 5'b10000, "inf_minus_inf");
      step(16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 5'b10000, "nan_in");
      step(16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 5'b00000, "inf_plus_one");
      step(16'h0401, 16'h0400, 1'b1, 16'h0000, 5'b00111, "underflow");
      step(16'h0001, 16'h0000, 1'b0, 16'h0000, 5'b00010, "subnormal_flush");
      step(16'h8000, 16'h8000, 1'b0, 16'h8000, 5'b00010, "neg_zero_sum");

      // random operands, biased toward near-equal magnitudes for cancellation
      for (int i = 0; i < 400; i++) begin
         x = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       y = x ^ 16'($urandom_range(0, 1023));
            1:       y = x ^ 16'h8000 ^ 16'($urandom_range(0, 7));
            2:       y = {1'b0, x[14:10], 10'($urandom)} ^ {16'($urandom) & 16'h8C00};
            default: y = 16'($urandom);
         endcase
         rstep(x, y, 1'($urandom), $sformatf("rand%0d", i));
      end

      // flush the pipeline with a known nonzero result
      for (int i = 0; i < 3; i++)
         step(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 5'b00000, "flush");

      // asynchronous reset clears the output without a clock edge
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      assert (result === 16'h0000 && flags === 5'b00000)
      else begin
         n_fail++;
         $error("FAIL async_reset: result=%h flags=%b, expected result=0000 flags=00000",
                result, flags);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
